// File: rtl/decode_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : decode_queue_if
// Description : Fetch-side and dispatch-side handshake bundle for decode_queue.
// Revision    : 1.0
// ============================================================================
interface decode_queue_if #(
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = 32,
    parameter int INSTR_ID_W = 6,
    parameter int IMM_W      = 32
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                  flush_in;
    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           instr_in;
    logic [ADDR_W-1:0]     pc_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [INSTR_ID_W-1:0] instr_id_out;
    logic [IMM_W-1:0]      imm_out;
    logic [4:0]            rs1_out;
    logic [4:0]            rs2_out;
    logic [4:0]            rd_out;
    logic [ADDR_W-1:0]     pc_out;
    logic                  illegal_out;
    logic [CNT_W-1:0]      count_out;

    modport slave (
        input  flush_in, in_valid, instr_in, pc_in, out_ready,
        output in_ready, out_valid, instr_id_out, imm_out, rs1_out, rs2_out,
               rd_out, pc_out, illegal_out, count_out
    );

    modport master (
        output flush_in, in_valid, instr_in, pc_in, out_ready,
        input  in_ready, out_valid, instr_id_out, imm_out, rs1_out, rs2_out,
               rd_out, pc_out, illegal_out, count_out
    );
endinterface
`default_nettype wire

// File: rtl/decode_queue.sv
`default_nettype none
// ============================================================================
// Module      : decode_queue
// Description : RV32I decoder feeding a DEPTH-entry in-order queue with flush.
//               Define RV32M_EN to also decode the RV32M multiply/divide ops.
// Revision    : 1.0
// ============================================================================
module decode_queue #(
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = 32,
    parameter int INSTR_ID_W = 6,
    parameter int IMM_W      = 32
) (
    input  wire logic      clk_in,
    input  wire logic      rst_n_in,
    decode_queue_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OPIMM  = 7'h13;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] F7_BASE    = 7'h00;
    localparam logic [6:0] F7_ALT     = 7'h20;

    // Instruction ids; 0 is reserved for illegal encodings
    localparam logic [INSTR_ID_W-1:0] ID_NONE  = INSTR_ID_W'(0);
    localparam logic [INSTR_ID_W-1:0] ID_LUI   = INSTR_ID_W'(1);
    localparam logic [INSTR_ID_W-1:0] ID_AUIPC = INSTR_ID_W'(2);
    localparam logic [INSTR_ID_W-1:0] ID_JAL   = INSTR_ID_W'(3);
    localparam logic [INSTR_ID_W-1:0] ID_JALR  = INSTR_ID_W'(4);
    localparam logic [INSTR_ID_W-1:0] ID_BEQ   = INSTR_ID_W'(5);
    localparam logic [INSTR_ID_W-1:0] ID_BNE   = INSTR_ID_W'(6);
    localparam logic [INSTR_ID_W-1:0] ID_BLT   = INSTR_ID_W'(7);
    localparam logic [INSTR_ID_W-1:0] ID_BGE   = INSTR_ID_W'(8);
    localparam logic [INSTR_ID_W-1:0] ID_BLTU  = INSTR_ID_W'(9);
    localparam logic [INSTR_ID_W-1:0] ID_BGEU  = INSTR_ID_W'(10);
    localparam logic [INSTR_ID_W-1:0] ID_LB    = INSTR_ID_W'(11);
    localparam logic [INSTR_ID_W-1:0] ID_LH    = INSTR_ID_W'(12);
    localparam logic [INSTR_ID_W-1:0] ID_LW    = INSTR_ID_W'(13);
    localparam logic [INSTR_ID_W-1:0] ID_LBU   = INSTR_ID_W'(14);
    localparam logic [INSTR_ID_W-1:0] ID_LHU   = INSTR_ID_W'(15);
    localparam logic [INSTR_ID_W-1:0] ID_SB    = INSTR_ID_W'(16);
    localparam logic [INSTR_ID_W-1:0] ID_SH    = INSTR_ID_W'(17);
    localparam logic [INSTR_ID_W-1:0] ID_SW    = INSTR_ID_W'(18);
    localparam logic [INSTR_ID_W-1:0] ID_ADDI  = INSTR_ID_W'(19);
    localparam logic [INSTR_ID_W-1:0] ID_SLTI  = INSTR_ID_W'(20);
    localparam logic [INSTR_ID_W-1:0] ID_SLTIU = INSTR_ID_W'(21);
    localparam logic [INSTR_ID_W-1:0] ID_XORI  = INSTR_ID_W'(22);
    localparam logic [INSTR_ID_W-1:0] ID_ORI   = INSTR_ID_W'(23);
    localparam logic [INSTR_ID_W-1:0] ID_ANDI  = INSTR_ID_W'(24);
    localparam logic [INSTR_ID_W-1:0] ID_SLLI  = INSTR_ID_W'(25);
    localparam logic [INSTR_ID_W-1:0] ID_SRLI  = INSTR_ID_W'(26);
    localparam logic [INSTR_ID_W-1:0] ID_SRAI  = INSTR_ID_W'(27);
    localparam logic [INSTR_ID_W-1:0] ID_ADD   = INSTR_ID_W'(28);
    localparam logic [INSTR_ID_W-1:0] ID_SUB   = INSTR_ID_W'(29);
    localparam logic [INSTR_ID_W-1:0] ID_SLL   = INSTR_ID_W'(30);
    localparam logic [INSTR_ID_W-1:0] ID_SLT   = INSTR_ID_W'(31);
    localparam logic [INSTR_ID_W-1:0] ID_SLTU  = INSTR_ID_W'(32);
    localparam logic [INSTR_ID_W-1:0] ID_XOR   = INSTR_ID_W'(33);
    localparam logic [INSTR_ID_W-1:0] ID_SRL   = INSTR_ID_W'(34);
    localparam logic [INSTR_ID_W-1:0] ID_SRA   = INSTR_ID_W'(35);
    localparam logic [INSTR_ID_W-1:0] ID_OR    = INSTR_ID_W'(36);
    localparam logic [INSTR_ID_W-1:0] ID_AND   = INSTR_ID_W'(37);
`ifdef RV32M_EN
    // MUL..REMU occupy consecutive ids in funct3 order
    localparam logic [INSTR_ID_W-1:0] ID_MUL    = INSTR_ID_W'(38);
    localparam logic [6:0]            F7_MULDIV = 7'h01;
`endif

    logic [31:0] w_instr;
    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm_sh;

    logic [INSTR_ID_W-1:0] w_id;
    logic [31:0]           w_imm;
    logic [4:0]            w_rs1, w_rs2, w_rd;
    logic                  w_ill;

    assign w_instr  = bus.instr_in;
    assign w_opc    = w_instr[6:0];
    assign w_f3     = w_instr[14:12];
    assign w_f7     = w_instr[31:25];
    assign w_imm_i  = {{20{w_instr[31]}}, w_instr[31:20]};
    assign w_imm_s  = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
    assign w_imm_b  = {{20{w_instr[31]}}, w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
    assign w_imm_u  = {w_instr[31:12], 12'b0};
    assign w_imm_j  = {{12{w_instr[31]}}, w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};
    assign w_imm_sh = {27'b0, w_instr[24:20]};

    always_comb begin
        w_id  = ID_NONE;
        w_imm = '0;
        w_rs1 = '0;
        w_rs2 = '0;
        w_rd  = '0;
        w_ill = 1'b0;
        case (w_opc)
            OPC_LUI:   begin w_id = ID_LUI;   w_imm = w_imm_u; w_rd = w_instr[11:7]; end
            OPC_AUIPC: begin w_id = ID_AUIPC; w_imm = w_imm_u; w_rd = w_instr[11:7]; end
            OPC_JAL:   begin w_id = ID_JAL;   w_imm = w_imm_j; w_rd = w_instr[11:7]; end
            OPC_JALR: begin
                w_id = ID_JALR; w_imm = w_imm_i; w_rs1 = w_instr[19:15]; w_rd = w_instr[11:7];
                w_ill = (w_f3 != 3'd0);
            end
            OPC_BRANCH: begin
                w_imm = w_imm_b; w_rs1 = w_instr[19:15]; w_rs2 = w_instr[24:20];
                case (w_f3)
                    3'd0: w_id = ID_BEQ;
                    3'd1: w_id = ID_BNE;
                    3'd4: w_id = ID_BLT;
                    3'd5: w_id = ID_BGE;
                    3'd6: w_id = ID_BLTU;
                    3'd7: w_id = ID_BGEU;
                    default: w_ill = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                w_imm = w_imm_i; w_rs1 = w_instr[19:15]; w_rd = w_instr[11:7];
                case (w_f3)
                    3'd0: w_id = ID_LB;
                    3'd1: w_id = ID_LH;
                    3'd2: w_id = ID_LW;
                    3'd4: w_id = ID_LBU;
                    3'd5: w_id = ID_LHU;
                    default: w_ill = 1'b1;
                endcase
            end
            OPC_STORE: begin
                w_imm = w_imm_s; w_rs1 = w_instr[19:15]; w_rs2 = w_instr[24:20];
                case (w_f3)
                    3'd0: w_id = ID_SB;
                    3'd1: w_id = ID_SH;
                    3'd2: w_id = ID_SW;
                    default: w_ill = 1'b1;
                endcase
            end
            OPC_OPIMM: begin
                w_imm = w_imm_i; w_rs1 = w_instr[19:15]; w_rd = w_instr[11:7];
                case (w_f3)
                    3'd0: w_id = ID_ADDI;
                    3'd2: w_id = ID_SLTI;
                    3'd3: w_id = ID_SLTIU;
                    3'd4: w_id = ID_XORI;
                    3'd6: w_id = ID_ORI;
                    3'd7: w_id = ID_ANDI;
                    3'd1: begin
                        w_imm = w_imm_sh; w_id = ID_SLLI;
                        w_ill = (w_f7 != F7_BASE);
                    end
                    default: begin
                        w_imm = w_imm_sh;
                        if (w_f7 == F7_BASE)     w_id  = ID_SRLI;
                        else if (w_f7 == F7_ALT) w_id  = ID_SRAI;
                        else                     w_ill = 1'b1;
                    end
                endcase
            end
            OPC_OP: begin
                w_rs1 = w_instr[19:15]; w_rs2 = w_instr[24:20]; w_rd = w_instr[11:7];
                if (w_f7 == F7_BASE) begin
                    case (w_f3)
                        3'd0: w_id = ID_ADD;
                        3'd1: w_id = ID_SLL;
                        3'd2: w_id = ID_SLT;
                        3'd3: w_id = ID_SLTU;
                        3'd4: w_id = ID_XOR;
                        3'd5: w_id = ID_SRL;
                        3'd6: w_id = ID_OR;
                        default: w_id = ID_AND;
                    endcase
                end else if (w_f7 == F7_ALT) begin
                    if (w_f3 == 3'd0)      w_id  = ID_SUB;
                    else if (w_f3 == 3'd5) w_id  = ID_SRA;
                    else                   w_ill = 1'b1;
                end
`ifdef RV32M_EN
                else if (w_f7 == F7_MULDIV) begin
                    w_id = ID_MUL + INSTR_ID_W'(w_f3);
                end
`endif
                else begin
                    w_ill = 1'b1;
                end
            end
            default: w_ill = 1'b1;
        endcase
        // Illegal entries carry only their pc and the flag
        if (w_ill) begin
            w_id  = ID_NONE;
            w_imm = '0;
            w_rs1 = '0;
            w_rs2 = '0;
            w_rd  = '0;
        end
    end

    logic [PTR_W-1:0]      r_head, r_tail;
    logic [CNT_W-1:0]      r_count;
    logic [INSTR_ID_W-1:0] r_id_mem  [DEPTH];
    logic [IMM_W-1:0]      r_imm_mem [DEPTH];
    logic [4:0]            r_rs1_mem [DEPTH];
    logic [4:0]            r_rs2_mem [DEPTH];
    logic [4:0]            r_rd_mem  [DEPTH];
    logic [ADDR_W-1:0]     r_pc_mem  [DEPTH];
    logic                  r_ill_mem [DEPTH];

    logic w_in_ready, w_out_valid, w_push, w_pop;

    assign w_in_ready  = (r_count < CNT_W'(DEPTH));
    assign w_out_valid = (r_count != '0);
    assign w_push      = bus.in_valid && w_in_ready;
    assign w_pop       = w_out_valid && bus.out_ready;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (bus.flush_in) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + PTR_W'(1);
            if (w_pop)  r_head <= r_head + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Storage needs no reset: outputs are masked whenever the queue is empty
    always_ff @(posedge clk_in) begin
        if (w_push && !bus.flush_in) begin
            r_id_mem[r_tail]  <= w_id;
            r_imm_mem[r_tail] <= IMM_W'(w_imm);
            r_rs1_mem[r_tail] <= w_rs1;
            r_rs2_mem[r_tail] <= w_rs2;
            r_rd_mem[r_tail]  <= w_rd;
            r_pc_mem[r_tail]  <= bus.pc_in;
            r_ill_mem[r_tail] <= w_ill;
        end
    end

    always_comb begin
        bus.instr_id_out = '0;
        bus.imm_out      = '0;
        bus.rs1_out      = '0;
        bus.rs2_out      = '0;
        bus.rd_out       = '0;
        bus.pc_out       = '0;
        bus.illegal_out  = 1'b0;
        if (w_out_valid) begin
            bus.instr_id_out = r_id_mem[r_head];
            bus.imm_out      = r_imm_mem[r_head];
            bus.rs1_out      = r_rs1_mem[r_head];
            bus.rs2_out      = r_rs2_mem[r_head];
            bus.rd_out       = r_rd_mem[r_head];
            bus.pc_out       = r_pc_mem[r_head];
            bus.illegal_out  = r_ill_mem[r_head];
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.count_out = r_count;
endmodule
`default_nettype wire

// File: tb/tb_decode_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_queue
// Description : Self-checking bench for decode_queue against a mask/match decode table
//               and a FIFO reference model. Honours RV32M_EN like the design.
// Revision    : 1.0
// ============================================================================
module tb_decode_queue;
    localparam int DEPTH = 8;
    localparam int FU = 0, FJ = 1, FI = 2, FB = 3, FS = 4, FR = 5, FSH = 6;

    typedef struct packed {
        logic [5:0]  id;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        ill;
    } ent_t;

    typedef struct {
        logic [31:0] mask;
        logic [31:0] match;
        int          id;
        int          fmt;
    } pat_t;

    pat_t pats[$];
    ent_t q[$];
    int   n_total = 0;
    int   n_bad   = 0;
    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic [31:0] pc_ctr = 32'h1000;

    always #5 clk = ~clk;

    decode_queue_if #(.DEPTH(DEPTH), .ADDR_W(32), .INSTR_ID_W(6), .IMM_W(32)) bus ();

    decode_queue #(.DEPTH(DEPTH), .ADDR_W(32), .INSTR_ID_W(6), .IMM_W(32)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus.slave)
    );

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic add_pat(input logic [31:0] mask, input logic [31:0] match, input int id, input int fmt);
        pat_t p;
        p.mask = mask; p.match = match; p.id = id; p.fmt = fmt;
        pats.push_back(p);
    endtask

    task automatic build_table();
        add_pat(32'h0000007F, 32'h00000037, 1, FU);
        add_pat(32'h0000007F, 32'h00000017, 2, FU);
        add_pat(32'h0000007F, 32'h0000006F, 3, FJ);
        add_pat(32'h0000707F, 32'h00000067, 4, FI);
        for (int k = 0; k < 6; k++) begin
            int f3;
            f3 = (k < 2) ? k : k + 2;
            add_pat(32'h0000707F, 32'h00000063 | (f3 << 12), 5 + k, FB);
        end
        add_pat(32'h0000707F, 32'h00000003, 11, FI);
        add_pat(32'h0000707F, 32'h00001003, 12, FI);
        add_pat(32'h0000707F, 32'h00002003, 13, FI);
        add_pat(32'h0000707F, 32'h00004003, 14, FI);
        add_pat(32'h0000707F, 32'h00005003, 15, FI);
        add_pat(32'h0000707F, 32'h00000023, 16, FS);
        add_pat(32'h0000707F, 32'h00001023, 17, FS);
        add_pat(32'h0000707F, 32'h00002023, 18, FS);
        add_pat(32'h0000707F, 32'h00000013, 19, FI);
        add_pat(32'h0000707F, 32'h00002013, 20, FI);
        add_pat(32'h0000707F, 32'h00003013, 21, FI);
        add_pat(32'h0000707F, 32'h00004013, 22, FI);
        add_pat(32'h0000707F, 32'h00006013, 23, FI);
        add_pat(32'h0000707F, 32'h00007013, 24, FI);
        add_pat(32'hFE00707F, 32'h00001013, 25, FSH);
        add_pat(32'hFE00707F, 32'h00005013, 26, FSH);
        add_pat(32'hFE00707F, 32'h40005013, 27, FSH);
        add_pat(32'hFE00707F, 32'h00000033, 28, FR);
        add_pat(32'hFE00707F, 32'h40000033, 29, FR);
        add_pat(32'hFE00707F, 32'h00001033, 30, FR);
        add_pat(32'hFE00707F, 32'h00002033, 31, FR);
        add_pat(32'hFE00707F, 32'h00003033, 32, FR);
        add_pat(32'hFE00707F, 32'h00004033, 33, FR);
        add_pat(32'hFE00707F, 32'h00005033, 34, FR);
        add_pat(32'hFE00707F, 32'h40005033, 35, FR);
        add_pat(32'hFE00707F, 32'h00006033, 36, FR);
        add_pat(32'hFE00707F, 32'h00007033, 37, FR);
`ifdef RV32M_EN
        for (int k = 0; k < 8; k++)
            add_pat(32'hFE00707F, 32'h02000033 | (k << 12), 38 + k, FR);
`endif
    endtask

    function automatic ent_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
        ent_t e;
        int   hit;
        logic [20:0] jt;
        logic [12:0] bt;
        logic [11:0] st;
        e = '0; e.pc = pc; e.ill = 1'b1; hit = -1;
        for (int k = 0; k < pats.size(); k++)
            if (hit < 0 && (w & pats[k].mask) == pats[k].match) hit = k;
        if (hit < 0) return e;
        e.ill = 1'b0;
        e.id  = 6'(pats[hit].id);
        jt = {w[31], w[19:12], w[20], w[30:21], 1'b0};
        bt = {w[31], w[7], w[30:25], w[11:8], 1'b0};
        st = {w[31:25], w[11:7]};
        case (pats[hit].fmt)
            FU:  begin e.imm = {w[31:12], 12'h000}; e.rd = w[11:7]; end
            FJ:  begin e.imm = 32'($signed(jt)); e.rd = w[11:7]; end
            FI:  begin e.imm = 32'($signed(w[31:20])); e.rs1 = w[19:15]; e.rd = w[11:7]; end
            FSH: begin e.imm = 32'(w[24:20]); e.rs1 = w[19:15]; e.rd = w[11:7]; end
            FB:  begin e.imm = 32'($signed(bt)); e.rs1 = w[19:15]; e.rs2 = w[24:20]; end
            FS:  begin e.imm = 32'($signed(st)); e.rs1 = w[19:15]; e.rs2 = w[24:20]; end
            default: begin e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7]; end
        endcase
        return e;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        int r;
        w = $urandom;
        r = $urandom_range(0, 9);
        if (r < 8) begin
            case ($urandom_range(0, 9))
                0: w[6:0] = 7'h37;  1: w[6:0] = 7'h17;  2: w[6:0] = 7'h6F;
                3: w[6:0] = 7'h67;  4: w[6:0] = 7'h03;  5: w[6:0] = 7'h23;
                6: w[6:0] = 7'h63;  7: w[6:0] = 7'h13;  8: w[6:0] = 7'h33;
                default: w[6:0] = 7'h73;
            endcase
            case ($urandom_range(0, 3))
                0: w[31:25] = 7'h00;
                1: w[31:25] = 7'h20;
                2: w[31:25] = 7'h01;
                default: ;
            endcase
        end
        return w;
    endfunction

    task automatic check_model(input string tag);
        ent_t e;
        e = (q.size() != 0) ? q[0] : '0;
        chk_eq({tag, ".out_valid"}, 64'(bus.out_valid), 64'(q.size() != 0));
        chk_eq({tag, ".in_ready"},  64'(bus.in_ready),  64'(q.size() < DEPTH));
        chk_eq({tag, ".count"},     64'(bus.count_out), 64'(q.size()));
        chk_eq({tag, ".id"},        64'(bus.instr_id_out), 64'(e.id));
        chk_eq({tag, ".imm"},       64'(bus.imm_out),   64'(e.imm));
        chk_eq({tag, ".rs1"},       64'(bus.rs1_out),   64'(e.rs1));
        chk_eq({tag, ".rs2"},       64'(bus.rs2_out),   64'(e.rs2));
        chk_eq({tag, ".rd"},        64'(bus.rd_out),    64'(e.rd));
        chk_eq({tag, ".pc"},        64'(bus.pc_out),    64'(e.pc));
        chk_eq({tag, ".illegal"},   64'(bus.illegal_out), 64'(e.ill));
    endtask

    // Called at a falling edge; applies inputs across the next rising edge
    task automatic step(input string tag, input logic v, input logic rdy, input logic fl,
                        input logic [31:0] ins, input logic [31:0] pc);
        bit push, pop;
        bus.in_valid  = v;
        bus.out_ready = rdy;
        bus.flush_in  = fl;
        bus.instr_in  = ins;
        bus.pc_in     = pc;
        if (fl) begin
            q.delete();
        end else begin
            push = v && (q.size() < DEPTH);
            pop  = rdy && (q.size() != 0);
            if (pop)  void'(q.pop_front());
            if (push) q.push_back(ref_decode(ins, pc));
        end
        @(negedge clk);
        check_model(tag);
    endtask

    function automatic logic [31:0] next_pc();
        pc_ctr = pc_ctr + 32'd4;
        return pc_ctr;
    endfunction

    task automatic mid_reset();
        #2 rst_n = 1'b0;
        #1;
        chk_eq("rst.out_valid", 64'(bus.out_valid), 64'd0);
        chk_eq("rst.in_ready",  64'(bus.in_ready),  64'd1);
        chk_eq("rst.count",     64'(bus.count_out), 64'd0);
        chk_eq("rst.data",      64'({bus.instr_id_out, bus.rs1_out, bus.rs2_out, bus.rd_out, bus.illegal_out}), 64'd0);
        chk_eq("rst.imm_pc",    {bus.imm_out, bus.pc_out}, 64'd0);
        q.delete();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.flush_in  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int pv, pr;
        build_table();
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.flush_in = 1'b0;
        bus.instr_in = '0;   bus.pc_in = '0;
        repeat (2) @(negedge clk);
        check_model("reset");
        rst_n = 1'b1;

        step("t1", 1'b1, 1'b0, 1'b0, 32'hFFF00093, 32'h100);
        chk_eq("t1.id_addi", 64'(bus.instr_id_out), 64'd19);
        chk_eq("t1.imm",     64'(bus.imm_out), 64'hFFFF_FFFF);
        chk_eq("t1.rd",      64'(bus.rd_out), 64'd1);
        chk_eq("t1.pc",      64'(bus.pc_out), 64'h100);
        step("t1d", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);

        step("t2a", 1'b1, 1'b0, 1'b0, 32'h0080006F, 32'h200);
        step("t2b", 1'b1, 1'b0, 1'b0, 32'hFE208EE3, 32'h204);
        chk_eq("t2.jal_id",  64'(bus.instr_id_out), 64'd3);
        chk_eq("t2.jal_imm", 64'(bus.imm_out), 64'd8);
        step("t2c", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        chk_eq("t2.beq_id",  64'(bus.instr_id_out), 64'd5);
        chk_eq("t2.beq_imm", 64'(bus.imm_out), 64'hFFFF_FFFC);
        chk_eq("t2.beq_regs", 64'({bus.rs1_out, bus.rs2_out, bus.rd_out}), 64'({5'd1, 5'd2, 5'd0}));
        step("t2d", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);

        for (int rep = 0; rep < 3; rep++) begin
            for (int i = 0; i < 9; i++) step("t3f", 1'b1, 1'b0, 1'b0, gen_instr(), next_pc());
            chk_eq("t3.full_count", 64'(bus.count_out), 64'd8);
            chk_eq("t3.full_ready", 64'(bus.in_ready), 64'd0);
            for (int i = 0; i < 8; i++) step("t3d", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
            chk_eq("t3.empty", 64'(bus.out_valid), 64'd0);
            step("t3s", 1'b1, 1'b1, 1'b0, gen_instr(), next_pc());
        end
        for (int i = 0; i < 8; i++) step("t3x", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);

        for (int i = 0; i < 3; i++) step("t4f", 1'b1, 1'b0, 1'b0, gen_instr(), next_pc());
        step("t4", 1'b1, 1'b1, 1'b1, 32'h00000013, next_pc());
        chk_eq("t4.count", 64'(bus.count_out), 64'd0);
        chk_eq("t4.valid", 64'(bus.out_valid), 64'd0);

        step("t5", 1'b1, 1'b0, 1'b0, 32'h022081B3, 32'h300);
`ifdef RV32M_EN
        chk_eq("t5.mul_id",  64'(bus.instr_id_out), 64'd38);
        chk_eq("t5.mul_ill", 64'(bus.illegal_out), 64'd0);
        chk_eq("t5.mul_rd",  64'(bus.rd_out), 64'd3);
`else
        chk_eq("t5.mul_ill", 64'(bus.illegal_out), 64'd1);
        chk_eq("t5.mul_id",  64'(bus.instr_id_out), 64'd0);
        chk_eq("t5.mul_rd",  64'(bus.rd_out), 64'd0);
`endif
        step("t5d", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);

        for (int i = 0; i < 8; i++) step("t6f", 1'b1, 1'b0, 1'b0, gen_instr(), next_pc());
        for (int i = 0; i < 20; i++) begin
            step("t6", 1'b1, 1'b1, 1'b0, gen_instr(), next_pc());
            if (i == 10) mid_reset();
        end

        for (int blk = 0; blk < 8; blk++) begin
            pv = $urandom_range(30, 95);
            pr = $urandom_range(30, 95);
            for (int i = 0; i < 200; i++)
                step("rnd", $urandom_range(0, 99) < pv, $urandom_range(0, 99) < pr,
                     $urandom_range(0, 49) == 0, gen_instr(), next_pc());
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
